// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480 framebuffer display path.
//   H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL : 640x480@60 timing dimensions
//   FB_PIXELS                         : pixels in one buffer
//   PIPE_LAT                          : cycles from hs/vs sample to pix_out
//   swap_state_t                      : double-buffer swap FSM states
package vga_pkg;
    localparam int H_ACTIVE  = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_ACTIVE  = 480;
    localparam int V_TOTAL   = 525;
    localparam int FB_PIXELS = 307200;
    localparam int PIPE_LAT  = 3;

    typedef enum logic {RUN, PENDING} swap_state_t;
endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align control/sync bits with the
// pixel pipeline.
//   clk_25 : clock
//   rst    : synchronous active-high reset, loads RST_VAL into every stage
//   din    : WIDTH-bit input
//   dout   : din delayed by DEPTH cycles
module sync_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_25) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/fb_display_arbiter.sv
// Arbitrates one single-port synchronous framebuffer RAM between VGA
// scan-out (active region, always wins) and a frame writer (blanking only),
// and double-buffers the framebuffer with swaps at the start of vblank.
//   clk_25, rst                    : pixel clock, sync active-high reset
//   hs, vs                         : timing generator counters
//   vga_hsync_in, vga_vsync_in     : active-low syncs from timing generator
//   wr_valid/wr_ready/wr_addr/wr_data : writer handshake into back buffer
//   swap_req, swap_ack             : swap request level / applied pulse
//   mem_addr/mem_we/mem_wdata/mem_rdata : RAM port (MSB of addr = buffer)
//   pix_out, de, vga_hsync, vga_vsync : aligned display outputs
//   front_sel                      : buffer currently scanned out
module fb_display_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 8
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic [9:0]        hs,
    input  logic [9:0]        vs,
    input  logic              vga_hsync_in,
    input  logic              vga_vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              de,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              front_sel
);
    import vga_pkg::swap_state_t;
    import vga_pkg::RUN;
    import vga_pkg::PENDING;
    import vga_pkg::PIPE_LAT;

    localparam logic [9:0]      H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0]      V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    logic              active;
    logic              frame_start;
    logic              accept;
    logic              wr_in_range;
    logic              swap_fire;
    swap_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              vld_p1, vld_p2;
    logic [2:0]        dly_out;

    assign active      = (hs < H_ACT_C) && (vs < V_ACT_C);
    assign frame_start = (hs == 10'd0) && (vs == V_ACT_C);
    assign wr_ready    = ~active & (state_q == RUN) & ~rst;
    assign accept      = wr_valid & wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < FB_LIMIT;
    assign swap_ack    = swap_fire & ~rst;

    // Swap FSM: the frame boundary is only examined once a request is pending,
    // so a request raised on the boundary cycle itself waits a whole frame.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_q   <= RUN;
            front_sel <= 1'b0;
        end else begin
            state_q <= state_d;
            if (swap_fire) front_sel <= ~front_sel;
        end
    end

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            RUN:     if (swap_req) state_d = PENDING;
            PENDING: if (frame_start) begin
                state_d   = RUN;
                swap_fire = 1'b1;
            end
        endcase
    end

    // Linear read pointer: raster order makes y*H_ACTIVE+x a simple counter
    // that restarts anywhere in vertical blanking.
    always_ff @(posedge clk_25) begin
        if (rst || vs >= V_ACT_C) rd_ptr_q <= '0;
        else if (active)          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end

    // Stage p1: RAM command register. Out-of-range writes complete the
    // handshake but leave the port idle (address held, no write).
    always_ff @(posedge clk_25) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= active;
            mem_we <= 1'b0;
            if (active) begin
                mem_addr <= {front_sel, rd_ptr_q};
            end else if (accept && wr_in_range) begin
                mem_addr  <= {~front_sel, wr_addr};
                mem_wdata <= wr_data;
                mem_we    <= 1'b1;
            end
        end
    end

    // Stage p2: RAM read data in flight.
    always_ff @(posedge clk_25) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    // Stage p3: pixel register, blanked outside the active region.
    always_ff @(posedge clk_25) begin
        if (rst) pix_out <= '0;
        else     pix_out <= vld_p2 ? mem_rdata : '0;
    end

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (3'b011)
    ) u_sync_dly (
        .clk_25 (clk_25),
        .rst    (rst),
        .din    ({active, vga_hsync_in, vga_vsync_in}),
        .dout   (dly_out)
    );

    assign de        = dly_out[2];
    assign vga_hsync = dly_out[1];
    assign vga_vsync = dly_out[0];
endmodule

// File: tb/tb_fb_display_arbiter.sv
module tb_fb_display_arbiter;
    logic        clk_25 = 1'b0;
    logic        rst;
    logic [9:0]  hs, vs;
    logic        vga_hsync_in, vga_vsync_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic [19:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_out;
    logic        de;
    logic        vga_hsync, vga_vsync;
    logic        front_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #20 clk_25 = ~clk_25;

    fb_display_arbiter dut (
        .clk_25       (clk_25),
        .rst          (rst),
        .hs           (hs),
        .vs           (vs),
        .vga_hsync_in (vga_hsync_in),
        .vga_vsync_in (vga_vsync_in),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .pix_out      (pix_out),
        .de           (de),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .front_sel    (front_sel)
    );

    // RAM model: synchronous read, contents are a fixed pattern of the address.
    function automatic logic [7:0] pat(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19], a[18:16], 4'h5};
    endfunction

    always @(posedge clk_25) mem_rdata <= pat(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int h, input int v);
        hs = 10'(h);
        vs = 10'(v);
        vga_hsync_in = !(h >= 656 && h < 752);
        vga_vsync_in = !(v >= 490 && v < 492);
    endtask

    task automatic tick(input int h, input int v);
        set_in(h, v);
        @(posedge clk_25);
        #1;
    endtask

    typedef struct {
        int          h;
        int          v;
        logic        vld;
        logic [18:0] addr;
        logic [7:0]  data;
        logic        exp_rdy;
        logic        exp_we;
        logic [19:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    logic       exp_de  [0:799];
    logic [7:0] exp_pix [0:799];
    logic       exp_hsy [0:799];

    initial begin
        // Writer vectors with front_sel = 0, so writes land in buffer 1.
        vecs[0] = '{100, 10,  1'b1, 19'd5,      8'hA5, 1'b0, 1'b0, 20'h0};
        vecs[1] = '{640, 10,  1'b1, 19'd5,      8'hA5, 1'b1, 1'b1, {1'b1, 19'd5}};
        vecs[2] = '{700, 10,  1'b0, 19'd5,      8'h11, 1'b1, 1'b0, 20'h0};
        vecs[3] = '{799, 10,  1'b1, 19'd1234,   8'h3C, 1'b1, 1'b1, {1'b1, 19'd1234}};
        vecs[4] = '{0,   480, 1'b1, 19'd307200, 8'hEE, 1'b1, 1'b0, 20'h0};
        vecs[5] = '{10,  500, 1'b1, 19'd307199, 8'h77, 1'b1, 1'b1, {1'b1, 19'd307199}};
        vecs[6] = '{639, 479, 1'b1, 19'd42,     8'h99, 1'b0, 1'b0, 20'h0};
        vecs[7] = '{0,   520, 1'b1, 19'd0,      8'hFF, 1'b1, 1'b1, {1'b1, 19'd0}};

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        set_in(100, 10);
        vga_hsync_in = 1'b0;
        vga_vsync_in = 1'b0;
        wr_valid = 1'b1;

        // Reset held for 3 cycles on an active line.
        repeat (3) begin
            @(posedge clk_25);
            #1;
        end
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pix_out",   pix_out,   0);
        chk("rst_de",        de,        0);
        chk("rst_hsync",     vga_hsync, 1);
        chk("rst_vsync",     vga_vsync, 1);
        chk("rst_wr_ready",  wr_ready,  0);
        chk("rst_swap_ack",  swap_ack,  0);
        chk("rst_front_sel", front_sel, 0);
        rst = 1'b0;
        wr_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].h, vecs[i].v);
            wr_valid = vecs[i].vld;
            wr_addr  = vecs[i].addr;
            wr_data  = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].exp_rdy);
            @(posedge clk_25);
            #1;
            chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_mem_addr", i),  mem_addr,  vecs[i].exp_addr);
                chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].data);
            end
        end
        wr_valid = 1'b0;

        // Contention: writer waits through the tail of the active line.
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 8'hA5;
        for (int h = 630; h <= 640; h++) begin
            set_in(h, 10);
            #1;
            chk($sformatf("cont_wr_ready_h%0d", h), wr_ready, (h == 640) ? 1 : 0);
            @(posedge clk_25);
            #1;
        end
        wr_valid = 1'b0;
        chk("cont_mem_we",    mem_we,    1);
        chk("cont_mem_addr",  mem_addr,  {1'b1, 19'd5});
        chk("cont_mem_wdata", mem_wdata, 8'hA5);

        // Display sweep: one vblank cycle, lines 0..9, then line 10 checked.
        tick(799, 524);
        for (int v = 0; v < 10; v++)
            for (int h = 0; h < 800; h++) tick(h, v);
        for (int h = 0; h < 800; h++) begin
            exp_de[h]  = (h < 640);
            exp_pix[h] = (h < 640) ? pat({1'b0, 19'(6400 + h)}) : 8'h00;
            exp_hsy[h] = !(h >= 656 && h < 752);
        end
        for (int h = 0; h < 802; h++) begin
            if (h < 800) set_in(h, 10);
            else         set_in(h - 800, 11);
            #1;
            if (h >= 640 && h < 800) chk($sformatf("sweep_wr_ready_h%0d", h), wr_ready, 1);
            @(posedge clk_25);
            #1;
            if (h < 640) chk($sformatf("sweep_mem_addr_h%0d", h), mem_addr, {1'b0, 19'(6400 + h)});
            if (h >= 2) begin
                chk($sformatf("sweep_de_h%0d", h - 2),    de,        exp_de[h-2]);
                chk($sformatf("sweep_pix_h%0d", h - 2),   pix_out,   exp_pix[h-2]);
                chk($sformatf("sweep_hsync_h%0d", h - 2), vga_hsync, exp_hsy[h-2]);
                chk($sformatf("sweep_vsync_h%0d", h - 2), vga_vsync, 1);
            end
        end

        // Swap requested mid-frame; counters are driven directly, so the
        // intervening lines are represented by a few sample points.
        swap_req = 1'b1;
        tick(0, 100);
        begin
            int pts_h[4] = '{700, 650, 0, 799};
            int pts_v[4] = '{100, 300, 479, 479};
            for (int i = 0; i < 4; i++) begin
                set_in(pts_h[i], pts_v[i]);
                #1;
                chk($sformatf("swap_wait_wr_ready%0d", i), wr_ready, 0);
                chk($sformatf("swap_wait_ack%0d", i),      swap_ack, 0);
                @(posedge clk_25);
                #1;
            end
        end
        set_in(0, 480);
        #1;
        chk("swap_bnd_wr_ready", wr_ready,  0);
        chk("swap_bnd_ack",      swap_ack,  1);
        chk("swap_bnd_front",    front_sel, 0);
        @(posedge clk_25);
        #1;
        swap_req = 1'b0;
        set_in(1, 480);
        #1;
        chk("swap_after_ack",      swap_ack,  0);
        chk("swap_after_wr_ready", wr_ready,  1);
        chk("swap_after_front",    front_sel, 1);
        @(posedge clk_25);
        #1;
        tick(0, 0);
        chk("next_frame_addr0", mem_addr, {1'b1, 19'd0});
        tick(1, 0);
        chk("next_frame_addr1", mem_addr, {1'b1, 19'd1});
        wr_valid = 1'b1; wr_addr = 19'd9; wr_data = 8'h5A;
        tick(700, 0);
        wr_valid = 1'b0;
        chk("back_write_we",   mem_we,   1);
        chk("back_write_addr", mem_addr, {1'b0, 19'd9});

        // Request first raised on the boundary cycle: waits one more frame.
        swap_req = 1'b1;
        set_in(0, 480);
        #1;
        chk("late_req_no_ack", swap_ack, 0);
        @(posedge clk_25);
        #1;
        set_in(1, 480);
        #1;
        chk("late_req_pending_wr_ready", wr_ready, 0);
        @(posedge clk_25);
        #1;
        tick(0, 481);
        tick(0, 524);
        tick(700, 0);
        set_in(799, 479);
        #1;
        chk("late_req_pre_bnd_ack", swap_ack, 0);
        @(posedge clk_25);
        #1;
        set_in(0, 480);
        #1;
        chk("late_req_bnd_ack",      swap_ack, 1);
        chk("late_req_bnd_wr_ready", wr_ready, 0);
        @(posedge clk_25);
        #1;
        swap_req = 1'b0;
        set_in(1, 480);
        #1;
        chk("late_req_front", front_sel, 0);
        chk("late_req_ack_done", swap_ack, 0);
        chk("late_req_wr_ready", wr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_display_arbiter.md
# fb_display_arbiter

Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a frame writer such as the NPU result writer. The VGA scan-out path is driven by the 640x480 timing generator's `hs`/`vs` counters. The block handles three jobs:
- During the active display region it issues one display read per pixel and returns the pixel with matching delayed syncs.
- During blanking it grants the RAM to the writer through a valid/ready handshake.
- It double-buffers the framebuffer, swapping front and back buffers only at the start of vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `ADDR_W`, default 19: address width of one buffer.
- `PIX_W`, default 8: pixel width.

Ports:
- `clk_25`, input, 1: pixel clock. This is the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `hs`, input, 10: horizontal counter from the timing generator, range 0..799.
- `vs`, input, 10: vertical counter from the timing generator, range 0..524.
- `vga_hsync_in`, input, 1: active-low horizontal sync from the timing generator.
- `vga_vsync_in`, input, 1: active-low vertical sync from the timing generator.
- `wr_valid`, input, 1: writer has a pixel to write.
- `wr_ready`, output, 1: block accepts the writer's pixel this cycle.
- `wr_addr`, input, `ADDR_W`: linear back-buffer address, computed as y*`H_ACTIVE`+x.
- `wr_data`, input, `PIX_W`: pixel value to write.
- `swap_req`, input, 1: level signal requesting a buffer swap; the writer has completed its frame.
- `swap_ack`, output, 1: one-cycle pulse when the swap is applied.
- `mem_addr`, output, `ADDR_W`+1: RAM address, registered. The MSB is the buffer select.
- `mem_we`, output, 1: RAM write enable, registered.
- `mem_wdata`, output, `PIX_W`: RAM write data, registered.
- `mem_rdata`, input, `PIX_W`: RAM read data, valid one cycle after `mem_addr`.
- `pix_out`, output, `PIX_W`: pixel to the DAC, registered.
- `de`, output, 1: pixel data enable, high while `pix_out` is an active pixel.
- `vga_hsync`, output, 1: `vga_hsync_in` delayed to align with `pix_out`.
- `vga_vsync`, output, 1: `vga_vsync_in` delayed to align with `pix_out`.
- `front_sel`, output, 1: index of the current display buffer.

## Operation
- **Active region.** `active` = (`hs` < `H_ACTIVE`) & (`vs` < `V_ACTIVE`), combinational from the inputs.
- **Read pointer.** `rd_ptr` (`ADDR_W` bits):
  - cleared to 0 on every cycle where `vs` >= `V_ACTIVE`;
  - incremented by 1 on every active cycle.
  - No multiplier is used.
- **Display read.** When `active`, the next `mem_addr` = {`front_sel`, `rd_ptr`} and `mem_we` = 0. Display reads always win.
- **Writer handshake.**
  - `wr_ready` = ~`active` & (state == RUN) & ~`rst`.
  - On `wr_valid` & `wr_ready`: the next `mem_addr` = {~`front_sel`, `wr_addr`}, `mem_wdata` = `wr_data`, and `mem_we` = 1.
  - A write with `wr_addr` >= `H_ACTIVE`*`V_ACTIVE` is still accepted (handshake completes) but is dropped: `mem_we` = 0.
- **Idle cycles.** When neither a display read nor a write occurs, `mem_we` = 0 and `mem_addr` holds its previous value.
- **Swap FSM.**
  - RUN: if `swap_req`, go to PENDING.
  - PENDING: `wr_ready` is forced to 0. When `hs` == 0 and `vs` == `V_ACTIVE`, toggle `front_sel`, pulse `swap_ack` for one cycle, and return to RUN.
  - The boundary is only checked in PENDING. A request that arrives on the boundary cycle itself waits for the next frame boundary.
  - `swap_req` held high after `swap_ack` re-enters PENDING on the next cycle. The writer must drop `swap_req` on `swap_ack`.
- **Reset mid-frame.** The pipeline is flushed and the state returns to RUN with `front_sel` = 0. Display resumes correctly at the next frame, because `rd_ptr` re-clears during vertical blanking. Output from the partial frame in progress is unspecified but `de`-gated.

## Timing
- **Display pipeline, sampled at cycle t:**
  - t+1: `mem_addr` registered.
  - t+2: `mem_rdata` valid.
  - t+3: `pix_out` registered.
- **Display latency.** `pix_out` for `hs`/`vs` sampled at cycle t appears at t+3. `de` is `active` delayed by 3. `vga_hsync` and `vga_vsync` are their inputs delayed by 3. `pix_out` = 0 whenever delayed `de` = 0.
- **Write latency.** An accepted write reaches the RAM port (`mem_we`) one cycle after acceptance.
- **Active-region boundaries.** The first write slot of each line is the cycle `hs` == `H_ACTIVE`. The last write slot before display is `hs` == 799, only when the next line is active.
- **Reset values:**
  - `mem_addr` = 0, `mem_we` = 0, `mem_wdata` = 0;
  - `pix_out` = 0, `de` = 0;
  - `vga_hsync` = 1, `vga_vsync` = 1;
  - `wr_ready` = 0, `swap_ack` = 0;
  - `front_sel` = 0, state = RUN, `rd_ptr` = 0, all delay stages cleared (syncs to 1).

## Structure
- **Package `vga_pkg`** holds:
  - the constants H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, FB_PIXELS=307200, and PIPE_LAT=3;
  - `typedef enum logic {RUN, PENDING} swap_state_t`.
- **Sub-module `sync_delay_line`** (parameters WIDTH and DEPTH, configurable reset value) delays {`de`, `vga_hsync_in`, `vga_vsync_in`} by PIPE_LAT.

## Test plan
- **Reset.** Assert `rst` for 3 cycles during an active line → every output is at its reset value; `vga_hsync` and `vga_vsync` read 1.
- **Display read and write window.**
  - Sweep `hs` 0..799 on `vs`=10 → `mem_addr` = {0, 6400+`hs`} for `hs`<640; `pix_out` = RAM model data 3 cycles later with `de`=1.
  - For `hs`=640..799: `de`=0 and `wr_ready`=1.
- **Writer contention.** `wr_valid`=1 with `wr_addr`=5, `wr_data`=0xA5 held from `hs`=630 → `wr_ready`=0 until `hs`=640; then `mem_we`=1 with `mem_addr`={1,5} and `mem_wdata`=0xA5 one cycle later.
- **Out-of-range write.** `wr_addr`=307200 accepted during blanking → handshake completes and `mem_we` stays 0.
- **Swap.**
  - `swap_req` raised at `vs`=100 → `wr_ready`=0 until the cycle `vs`=480, `hs`=0.
  - At that cycle `swap_ack` pulses and `front_sel`=1.
  - Reads of the next frame use MSB=1.
- **Swap on the boundary cycle.** `swap_req` first raised exactly at `vs`=480, `hs`=0 → no swap in that frame; `swap_ack` occurs one frame later, after 420000 cycles.
